vscale_hpm_counters: RTL and testbench
======================================

VSCALE_HPM_COUNTERS -- requirements
Module: vscale_hpm_counters

Interface
REQ-001 Parameter N_HPM, 4, number of programmable counters mhpmcounter3..mhpmcounter(2+N_HPM); legal range 1..29.
REQ-002 Parameter CNT_WIDTH, 64, implemented width of every counter; legal range 33..64.
REQ-003 Parameter N_EVENTS, 8, width of the event input vector; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 prv  input  PRV_WIDTH  current privilege level.
REQ-007 req  input  1  CSR access valid this cycle.
REQ-008 cmd  input  CSR_CMD_WIDTH  CSR command; uses the existing READ/WRITE/SET/CLEAR encodings.
REQ-009 addr  input  CSR_ADDR_WIDTH  CSR address.
REQ-010 wdata  input  XPR_LEN  write operand.
REQ-011 rdata  output  XPR_LEN  combinational read data for addr.
REQ-012 illegal_access  output  1  combinational access fault.
REQ-013 retire  input  1  one instruction retired this cycle.
REQ-014 events  input  N_EVENTS  single-cycle event pulses.
REQ-015 ovf_irq  output  1  registered counter-overflow interrupt request.

Function
REQ-016 Address map: mcycle B00/B80, minstret B02/B82, mhpmcounterK B00+K/B80+K, mcountinhibit 320, mhpmeventK 320+K, mcounteren 306, user read-only shadows C00+x/C80+x, movf 7C0, movfen 7C1; K = 3..2+N_HPM.
REQ-017 Undefined addresses SHALL read 0 and set defined=0.
REQ-018 Write value SHALL be rdata|wdata for SET, rdata&~wdata for CLEAR, and wdata for WRITE.
REQ-019 The write SHALL commit at the clock edge only when req=1, the cmd is WRITE/SET/CLEAR, and illegal_access=0.
REQ-020 illegal_access SHALL assert on any of: undefined addr with cmd[2]; write with addr[11:10]=11; addr[9:8]>prv; U-mode shadow read with mcounteren[addr[4:0]]=0.
REQ-021 events and retire SHALL be registered once (ev_q, ret_q); a pulse at cycle t SHALL be visible in rdata at t+2.
REQ-022 mcycle SHALL increment every cycle while mcountinhibit[0]=0, with no sampling stage.
REQ-023 minstret SHALL increment on ret_q while mcountinhibit[2]=0.
REQ-024 Counter K SHALL increment on ev_q[v-1] while mcountinhibit[K]=0, where v = mhpmeventK and 1<=v<=N_EVENTS.
REQ-025 mhpmeventK with v=0 or v>N_EVENTS SHALL count nothing.
REQ-026 mhpmeventK SHALL store bits [7:0]; upper bits SHALL read 0.
REQ-027 mcountinhibit and mcounteren SHALL implement bits 0, 2, and 3..2+N_HPM only; all other bits, including bit 1, SHALL read 0 and ignore writes.
REQ-028 Counters SHALL wrap modulo 2^CNT_WIDTH; bits at or above CNT_WIDTH SHALL read 0 and ignore writes.
REQ-029 A low-half write SHALL replace [31:0] and preserve the high half; a high-half write SHALL replace [CNT_WIDTH-1:32] and preserve the low half.
REQ-030 A CSR write in the same cycle as an increment of that counter SHALL load the written value; that increment is lost.
REQ-031 A carry out of the low half SHALL propagate into the high half in the same cycle.
REQ-032 Wrap from all-ones to zero SHALL set sticky movf[k]; in a same-cycle software clear of that bit, the hardware set SHALL win.
REQ-033 ovf_irq SHALL equal the registered value of |(movf & movfen), one cycle after movf/movfen update.

Reset
REQ-034 reset_n low SHALL asynchronously clear all counters, mhpmevent*, mcountinhibit, mcounteren, movf, movfen, ev_q, ret_q and ovf_irq to 0.
REQ-035 rdata SHALL read 0 for every defined address while in reset.
REQ-036 Events and retire asserted during reset SHALL be dropped.
REQ-037 After reset release, mcycle SHALL read 1 one edge later; event counts start two edges after release.

Structure
REQ-038 New addresses (306, 320, 323+, 7C0, 7C1, C80+) SHALL be added to vscale_csr_addr_map.vh.
REQ-039 Command codes SHALL come from vscale_ctrl_constants.vh; parameter limits SHALL be defined in vscale_platform_constants.vh.
REQ-040 The block SHALL use one sub-module, vscale_hpm_counter: CNT_WIDTH counter with half-write, increment enable and wrap pulse, instantiated N_HPM+2 times by generate.

Verification
REQ-041 Write mhpmevent3=2; pulse events[1] 5 times; read B03 -> 5. Set mcountinhibit[3]; pulse 3 more -> still 5.
REQ-042 Write B03=FFFFFFFF, B83=FFFFFFFF; movfen=8; one event -> B03=0, B83=0, movf=8, ovf_irq=1 next cycle.
REQ-043 Write B03 in the same cycle as a counted event -> written value read back, not value+1.
REQ-044 prv=U, mcounteren=0, read C00 -> illegal_access=1. Set mcounteren[0]=1 -> read C00 is legal and returns mcycle low.
REQ-045 CNT_WIDTH=40: write B80=FFFFFFFF -> read B80 = 000000FF.
REQ-046 Drop reset_n mid-count with nonzero counters -> all reads 0 immediately; mcycle=1 one edge after release.

Source files
------------

// File: rtl/vscale_hpm_counters_pkg.sv
// Shared constants for the vscale hardware performance counters:
// CSR command codes, privilege levels, CSR addresses and parameter limits.
package vscale_hpm_counters_pkg;

   localparam int XPR_LEN        = 32;
   localparam int CSR_ADDR_WIDTH = 12;
   localparam int CSR_CMD_WIDTH  = 3;
   localparam int PRV_WIDTH      = 2;

   typedef enum logic [CSR_CMD_WIDTH-1:0] {
      CSR_IDLE  = 3'd0,
      CSR_READ  = 3'd4,
      CSR_WRITE = 3'd5,
      CSR_SET   = 3'd6,
      CSR_CLEAR = 3'd7
   } csr_cmd_e;

   localparam logic [PRV_WIDTH-1:0] PRV_U = 2'd0;
   localparam logic [PRV_WIDTH-1:0] PRV_M = 2'd3;

   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MCYCLE        = 12'hB00;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MCYCLEH       = 12'hB80;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_CYCLE         = 12'hC00;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_CYCLEH        = 12'hC80;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MCOUNTEREN    = 12'h306;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MOVF          = 12'h7C0;
   localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_MOVFEN        = 12'h7C1;

   localparam int N_HPM_MIN     = 1;
   localparam int N_HPM_MAX     = 29;
   localparam int CNT_WIDTH_MIN = 33;
   localparam int CNT_WIDTH_MAX = 64;
   localparam int N_EVENTS_MIN  = 1;
   localparam int N_EVENTS_MAX  = 255;

   // Counter slot i -> CSR index: slot 0 is mcycle (0), slot 1 is
   // minstret (2), slot 2+ are mhpmcounter3 upward.
   function automatic int cnt_csr_idx(input int i);
      return (i == 0) ? 0 : i + 1;
   endfunction

   // Bits that exist in mcountinhibit/mcounteren/movf/movfen.
   function automatic logic [31:0] cnt_mask(input int n_hpm);
      logic [31:0] m;
      m = 32'h0000_0005;
      for (int k = 3; k < 32; k++)
         if (k <= 2 + n_hpm) m[k] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/vscale_hpm_counters_if.sv
// CSR access bus between the core CSR file and the counter block.
// master: prv/req/cmd/addr/wdata out, rdata/illegal_access in.
interface vscale_hpm_counters_if;
   import vscale_hpm_counters_pkg::*;

   logic [PRV_WIDTH-1:0]      prv;
   logic                      req;
   logic [CSR_CMD_WIDTH-1:0]  cmd;
   logic [CSR_ADDR_WIDTH-1:0] addr;
   logic [XPR_LEN-1:0]        wdata;
   logic [XPR_LEN-1:0]        rdata;
   logic                      illegal_access;

   modport master (
      output prv, req, cmd, addr, wdata,
      input  rdata, illegal_access
   );

   modport slave (
      input  prv, req, cmd, addr, wdata,
      output rdata, illegal_access
   );

endinterface

// File: rtl/vscale_hpm_counter.sv
// One CNT_WIDTH counter with independent low/high 32-bit half writes.
// Ports: inc (count enable), wr_lo/wr_hi + wdata, value, wrap pulse.
module vscale_hpm_counter
   import vscale_hpm_counters_pkg::*;
#(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [XPR_LEN-1:0]   wdata,
   output logic [CNT_WIDTH-1:0] value,
   output logic                 wrap
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] nxt;

   // A software write wins over a same-cycle increment.
   always_comb begin
      nxt = value;
      if (wr_lo)
         nxt = {value[CNT_WIDTH-1:32], wdata};
      else if (wr_hi)
         nxt = {wdata[CNT_WIDTH-33:0], value[31:0]};
      else if (inc)
         nxt = value + ONE;
   end

   assign wrap = inc & ~wr_lo & ~wr_hi & (&value);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) value <= '0;
      else          value <= nxt;
   end

endmodule

// File: rtl/vscale_hpm_counters.sv
// Machine counters (mcycle, minstret, mhpmcounterK) with CSR access,
// inhibit/enable/event-select CSRs and sticky overflow interrupt.
// Ports: clk, reset_n, csr (slave bus), retire, events, ovf_irq.
module vscale_hpm_counters
   import vscale_hpm_counters_pkg::*;
#(
   parameter int N_HPM     = 4,
   parameter int CNT_WIDTH = 64,
   parameter int N_EVENTS  = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   vscale_hpm_counters_if.slave csr,
   input  logic                retire,
   input  logic [N_EVENTS-1:0] events,
   output logic                ovf_irq
);

   localparam int NC = N_HPM + 2;
   localparam logic [31:0] MASK = cnt_mask(N_HPM);

   logic [N_EVENTS-1:0]  ev_q;
   logic                 ret_q;
   logic [31:0]          inhibit;
   logic [31:0]          counteren;
   logic [31:0]          movf;
   logic [31:0]          movfen;
   logic [7:0]           hpm_evt [N_HPM];
   logic [CNT_WIDTH-1:0] cnt [NC];
   logic [NC-1:0]        inc;
   logic [NC-1:0]        wr_lo;
   logic [NC-1:0]        wr_hi;
   logic [NC-1:0]        wrap;
   logic [31:0]          wrap_bits;

   logic [4:0]  cidx;
   logic        cnt_hit, cnt_lo, cnt_hi, shadow;
   logic        is_inh, is_en, is_movf, is_movfen, is_evt;
   logic        defined, wen, illegal, commit;
   logic [63:0] val64;
   logic [7:0]  evt_rd;
   logic [31:0] rdata, wval;

   always_comb begin
      cidx      = csr.addr[4:0];
      cnt_hit   = (csr.addr[6:5] == 2'b00) && MASK[cidx];
      cnt_lo    = cnt_hit &&
                  ((csr.addr[11:7] == CSR_ADDR_MCYCLE[11:7]) ||
                   (csr.addr[11:7] == CSR_ADDR_CYCLE[11:7]));
      cnt_hi    = cnt_hit &&
                  ((csr.addr[11:7] == CSR_ADDR_MCYCLEH[11:7]) ||
                   (csr.addr[11:7] == CSR_ADDR_CYCLEH[11:7]));
      shadow    = cnt_hit && (csr.addr[11:10] == 2'b11);
      is_inh    = csr.addr == CSR_ADDR_MCOUNTINHIBIT;
      is_en     = csr.addr == CSR_ADDR_MCOUNTEREN;
      is_movf   = csr.addr == CSR_ADDR_MOVF;
      is_movfen = csr.addr == CSR_ADDR_MOVFEN;
      is_evt    = (csr.addr[11:5] == CSR_ADDR_MCOUNTINHIBIT[11:5]) &&
                  (int'(cidx) >= 3) && (int'(cidx) <= 2 + N_HPM);
      defined   = cnt_lo | cnt_hi | is_inh | is_en |
                  is_movf | is_movfen | is_evt;

      val64 = '0;
      for (int i = 0; i < NC; i++)
         if (int'(cidx) == cnt_csr_idx(i)) val64 = 64'(cnt[i]);
      evt_rd = '0;
      for (int k = 0; k < N_HPM; k++)
         if (int'(cidx) == k + 3) evt_rd = hpm_evt[k];

      rdata = '0;
      unique case (1'b1)
         cnt_lo:    rdata = val64[31:0];
         cnt_hi:    rdata = val64[63:32];
         is_inh:    rdata = inhibit;
         is_en:     rdata = counteren;
         is_movf:   rdata = movf;
         is_movfen: rdata = movfen;
         is_evt:    rdata = {24'b0, evt_rd};
         default:   rdata = '0;
      endcase

      wen = (csr.cmd == CSR_WRITE) || (csr.cmd == CSR_SET) ||
            (csr.cmd == CSR_CLEAR);
      illegal = (~defined & csr.cmd[2]) |
                (wen & (csr.addr[11:10] == 2'b11)) |
                (csr.addr[9:8] > csr.prv) |
                ((csr.prv == PRV_U) & shadow & ~counteren[cidx]);
      commit = csr.req & wen & ~illegal;

      wval = csr.wdata;
      if (csr.cmd == CSR_SET)   wval = rdata | csr.wdata;
      if (csr.cmd == CSR_CLEAR) wval = rdata & ~csr.wdata;
   end

   assign csr.rdata          = rdata;
   assign csr.illegal_access = illegal;

   always_comb begin
      logic hit;
      inc       = '0;
      wr_lo     = '0;
      wr_hi     = '0;
      wrap_bits = '0;
      inc[0] = ~inhibit[0];
      inc[1] = ret_q & ~inhibit[2];
      for (int k = 0; k < N_HPM; k++) begin
         hit = 1'b0;
         for (int e = 0; e < N_EVENTS; e++)
            if (int'(hpm_evt[k]) == e + 1) hit = ev_q[e];
         inc[k+2] = hit & ~inhibit[k+3];
      end
      for (int i = 0; i < NC; i++) begin
         wr_lo[i] = commit & cnt_lo & (int'(cidx) == cnt_csr_idx(i));
         wr_hi[i] = commit & cnt_hi & (int'(cidx) == cnt_csr_idx(i));
         wrap_bits[cnt_csr_idx(i)] = wrap[i];
      end
   end

   for (genvar i = 0; i < NC; i++) begin : g_cnt
      vscale_hpm_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (inc[i]),
         .wr_lo   (wr_lo[i]),
         .wr_hi   (wr_hi[i]),
         .wdata   (wval),
         .value   (cnt[i]),
         .wrap    (wrap[i])
      );
   end

   // Overflow set from hardware ORs over any software write,
   // so a clear racing a wrap leaves the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ev_q      <= '0;
         ret_q     <= 1'b0;
         inhibit   <= '0;
         counteren <= '0;
         movf      <= '0;
         movfen    <= '0;
         ovf_irq   <= 1'b0;
         for (int k = 0; k < N_HPM; k++) hpm_evt[k] <= '0;
      end else begin
         ev_q    <= events;
         ret_q   <= retire;
         ovf_irq <= |(movf & movfen);
         if (commit && is_inh)    inhibit   <= wval & MASK;
         if (commit && is_en)     counteren <= wval & MASK;
         if (commit && is_movfen) movfen    <= wval & MASK;
         movf <= (((commit && is_movf) ? wval : movf) & MASK) | wrap_bits;
         for (int k = 0; k < N_HPM; k++)
            if (commit && is_evt && (int'(cidx) == k + 3))
               hpm_evt[k] <= wval[7:0];
      end
   end

endmodule

// File: tb/tb_vscale_hpm_counters.sv
// Directed bench for vscale_hpm_counters: default instance plus a
// CNT_WIDTH=40 instance for the narrow high-half check.
module tb_vscale_hpm_counters;
   import vscale_hpm_counters_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       retire;
   logic [7:0] events;
   logic       ovf_irq;
   logic       retire40 = 1'b0;
   logic [7:0] events40 = 8'h00;
   logic       ovf_irq40;

   int n_checks = 0;
   int n_errors = 0;

   vscale_hpm_counters_if bus ();
   vscale_hpm_counters_if bus40 ();

   vscale_hpm_counters #(
      .N_HPM (4), .CNT_WIDTH (64), .N_EVENTS (8)
   ) u_dut (
      .clk (clk), .reset_n (reset_n), .csr (bus),
      .retire (retire), .events (events), .ovf_irq (ovf_irq)
   );

   vscale_hpm_counters #(
      .N_HPM (4), .CNT_WIDTH (40), .N_EVENTS (8)
   ) u_dut40 (
      .clk (clk), .reset_n (reset_n), .csr (bus40),
      .retire (retire40), .events (events40), .ovf_irq (ovf_irq40)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Combinational probe; no clock edge is crossed.
   task automatic acc(input logic [2:0] c, input logic [11:0] a,
                      output logic [31:0] d, output logic ill);
      bus.req = 1'b0; bus.cmd = c; bus.addr = a;
      #1;
      d = bus.rdata; ill = bus.illegal_access;
      bus.cmd = CSR_IDLE;
   endtask

   task automatic wr(input logic [2:0] c, input logic [11:0] a,
                     input logic [31:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = d;
      @(negedge clk);
      bus.req = 1'b0; bus.cmd = CSR_IDLE;
   endtask

   task automatic pulse_ev(input int i);
      @(negedge clk);
      events = '0; events[i] = 1'b1;
      @(negedge clk);
      events = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        ill;
      reset_n = 1'b0; retire = 1'b1; events = 8'hFF;
      bus.prv = PRV_M; bus.req = 1'b0; bus.cmd = CSR_IDLE;
      bus.addr = '0; bus.wdata = '0;
      bus40.prv = PRV_M; bus40.req = 1'b0; bus40.cmd = CSR_IDLE;
      bus40.addr = '0; bus40.wdata = '0;
      tick(3);
      acc(CSR_READ, 12'hB00, d, ill); check("rst_mcycle", d, 0);
      acc(CSR_READ, 12'hB03, d, ill); check("rst_hpm3", d, 0);
      acc(CSR_READ, 12'h7C0, d, ill); check("rst_movf", d, 0);
      retire = 1'b0; events = '0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      acc(CSR_READ, 12'hB00, d, ill); check("mcycle_release", d, 1);
      acc(CSR_READ, 12'hB02, d, ill); check("minstret_drop", d, 0);
      acc(CSR_READ, 12'h7FF, d, ill);
      check("undef_rdata", d, 0); check("undef_ill", ill, 1);
      acc(CSR_READ, 12'hB01, d, ill); check("b01_ill", ill, 1);

      wr(CSR_WRITE, 12'h323, 32'h0000_0102);
      acc(CSR_READ, 12'h323, d, ill); check("evt_upper", d, 2);
      repeat (5) pulse_ev(1);
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("hpm3_count5", d, 5);
      wr(CSR_SET, 12'h320, 32'h8);
      acc(CSR_READ, 12'h320, d, ill); check("inhibit_set", d, 8);
      repeat (3) pulse_ev(1);
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("hpm3_inhibited", d, 5);
      wr(CSR_WRITE, 12'h320, 32'hFFFF_FFFF);
      acc(CSR_READ, 12'h320, d, ill); check("inhibit_mask", d, 32'h7D);
      wr(CSR_WRITE, 12'h320, 32'h0);

      wr(CSR_WRITE, 12'hB03, 32'hFFFF_FFFF);
      wr(CSR_WRITE, 12'hB83, 32'hFFFF_FFFF);
      acc(CSR_READ, 12'hB83, d, ill); check("hpm3h_write", d, 32'hFFFF_FFFF);
      wr(CSR_WRITE, 12'h7C1, 32'h8);
      pulse_ev(1);
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("wrap_lo", d, 0);
      acc(CSR_READ, 12'hB83, d, ill); check("wrap_hi", d, 0);
      acc(CSR_READ, 12'h7C0, d, ill); check("movf_set", d, 8);
      check("irq_delay", ovf_irq, 0);
      tick(1);
      check("irq_set", ovf_irq, 1);

      wr(CSR_WRITE, 12'hB03, 32'hFFFF_FFFF);
      wr(CSR_WRITE, 12'hB83, 32'hFFFF_FFFF);
      @(negedge clk); events[1] = 1'b1;
      @(negedge clk); events = '0;
      bus.req = 1'b1; bus.cmd = CSR_CLEAR;
      bus.addr = 12'h7C0; bus.wdata = 32'h8;
      @(negedge clk); bus.req = 1'b0; bus.cmd = CSR_IDLE;
      acc(CSR_READ, 12'h7C0, d, ill); check("movf_hw_wins", d, 8);
      acc(CSR_READ, 12'hB03, d, ill); check("wrap_again", d, 0);
      wr(CSR_CLEAR, 12'h7C0, 32'h8);
      acc(CSR_READ, 12'h7C0, d, ill); check("movf_clear", d, 0);
      tick(1);
      check("irq_clear", ovf_irq, 0);

      @(negedge clk); events[1] = 1'b1;
      @(negedge clk); events = '0;
      bus.req = 1'b1; bus.cmd = CSR_WRITE;
      bus.addr = 12'hB03; bus.wdata = 32'h55;
      @(negedge clk); bus.req = 1'b0; bus.cmd = CSR_IDLE;
      acc(CSR_READ, 12'hB03, d, ill); check("wr_beats_inc", d, 32'h55);

      wr(CSR_WRITE, 12'hB83, 32'hAB);
      acc(CSR_READ, 12'hB83, d, ill); check("hi_write", d, 32'hAB);
      acc(CSR_READ, 12'hB03, d, ill); check("lo_kept", d, 32'h55);
      wr(CSR_WRITE, 12'hB03, 32'hFFFF_FFFF);
      acc(CSR_READ, 12'hB83, d, ill); check("hi_kept", d, 32'hAB);
      pulse_ev(1);
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("carry_lo", d, 0);
      acc(CSR_READ, 12'hB83, d, ill); check("carry_hi", d, 32'hAC);
      acc(CSR_READ, 12'h7C0, d, ill); check("no_full_wrap", d, 0);

      wr(CSR_WRITE, 12'h323, 32'h9);
      acc(CSR_READ, 12'h323, d, ill); check("evt_store9", d, 9);
      @(negedge clk); events = 8'hFF;
      @(negedge clk); events = '0;
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("evt_out_of_range", d, 0);
      acc(CSR_READ, 12'hB04, d, ill); check("evt_zero_sel", d, 0);
      wr(CSR_WRITE, 12'h323, 32'h8);
      pulse_ev(7);
      tick(1);
      acc(CSR_READ, 12'hB03, d, ill); check("evt_top", d, 1);

      repeat (3) begin
         @(negedge clk); retire = 1'b1;
         @(negedge clk); retire = 1'b0;
      end
      tick(1);
      acc(CSR_READ, 12'hB02, d, ill); check("minstret", d, 3);

      wr(CSR_WRITE, 12'h320, 32'h1);
      wr(CSR_WRITE, 12'hB00, 32'h1234_5678);
      bus.prv = PRV_U;
      acc(CSR_READ, 12'hC00, d, ill); check("u_cycle_denied", ill, 1);
      acc(CSR_READ, 12'h320, d, ill); check("u_mcsr_denied", ill, 1);
      bus.prv = PRV_M;
      acc(CSR_WRITE, 12'hC00, d, ill); check("shadow_write_ill", ill, 1);
      wr(CSR_WRITE, 12'h306, 32'hFFFF_FFFF);
      acc(CSR_READ, 12'h306, d, ill); check("counteren_mask", d, 32'h7D);
      bus.prv = PRV_U;
      acc(CSR_READ, 12'hC00, d, ill);
      check("u_cycle_ok", ill, 0); check("u_cycle_val", d, 32'h1234_5678);
      bus.prv = PRV_M;

      @(negedge clk);
      bus40.req = 1'b1; bus40.cmd = CSR_WRITE;
      bus40.addr = 12'hB80; bus40.wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus40.req = 1'b0; bus40.cmd = CSR_READ;
      #1;
      check("w40_hi", bus40.rdata, 32'h0000_00FF);
      bus40.cmd = CSR_IDLE;

      wr(CSR_WRITE, 12'h320, 32'h0);
      tick(2);
      reset_n = 1'b0;
      acc(CSR_READ, 12'hB00, d, ill); check("rst_async_mcycle", d, 0);
      acc(CSR_READ, 12'hB03, d, ill); check("rst_async_hpm3", d, 0);
      acc(CSR_READ, 12'h306, d, ill); check("rst_async_en", d, 0);
      bus40.cmd = CSR_READ; bus40.addr = 12'hB80;
      #1;
      check("rst_async_w40", bus40.rdata, 0);
      bus40.cmd = CSR_IDLE;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      acc(CSR_READ, 12'hB00, d, ill); check("mcycle_rerelease", d, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
